char_buffer_ctrl: RTL and testbench
===================================

// Module: char_buffer_ctrl
// PURPOSE
//  Terminal write controller for the 64x16 char generator: accepts a byte stream, owns the cursor,
//  writes printable codes into the char buffer, handles CR/LF/BS, and scrolls by advancing the
//  generator's first_row, then blanking the recycled line. Sits between the host byte source and
//  char_generator's buffer_* write ports.
// PARAMETERS
//  COLS   64  columns per line (power of 2; col width = log2(COLS))
//  ROWS   16  text lines (power of 2; row width = log2(ROWS))
//  BLANK  8'h20  code written when clearing cells
// PORTS
//  clk                   in   1   pixel clock; the single clock
//  clr_n                 in   1   asynchronous active-low reset
//  in_valid              in   1   byte offered
//  in_data               in   8   byte (ASCII)
//  in_ready              out  1   controller accepts; transfer when in_valid & in_ready
//  buffer_waddr          out  10  char buffer write address {phys_row, col}
//  buffer_din            out  8   char buffer write data
//  buffer_wen            out  1   char buffer write strobe, one cell per cycle
//  buffer_first_row      out  4   physical row shown at top of screen
//  buffer_first_row_wen  out  1   one-cycle strobe loading buffer_first_row into generator
//  cursor_row            out  4   logical cursor line (0 = top of screen)
//  cursor_col            out  6   cursor column
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, first_row=0, cursor (0,0), state CLEAR_ALL.
//  - phys_row = (first_row + cursor_row) mod ROWS; widths wrap naturally, no saturation.
//  - CLEAR_ALL: in_ready=0; 1024 consecutive wen cycles, waddr 0..1023, din=BLANK; on the final
//    write, first_row_wen=1 with first_row=0; next cycle IDLE.
//  - IDLE: in_ready=1. Accepted byte -> effect on outputs next cycle (latency 1, throughput 1/clk):
//    * 8'h20..8'h7E: wen=1, waddr={phys_row,col}, din=byte; col+1 if col<COLS-1 (see AUTO_WRAP_EN).
//    * 8'h0D CR: col=0, no write.   * 8'h08 BS: col-1, saturate at 0, no write.
//    * 8'h0A LF: row<ROWS-1 -> row+1; row==ROWS-1 -> SCROLL, row stays ROWS-1.
//    * any other code: consumed, ignored.
//  - SCROLL (accept cycle N): N+1 first_row_wen=1, first_row=old+1 (mod 16), in_ready=0, state
//    CLEAR_LINE. Write cycles N+1..N+64: wen=1, din=BLANK, waddr={old first_row, 0..63}
//    (recycled line, now bottom). in_ready=1 at N+65. No input accepted while busy.
//  - wen is never asserted in the same cycle as a different-address write; a single write port.
//  - Reset asserted mid-operation (any state): immediate async return to reset values; CLEAR_ALL
//    restarts from address 0 after release.
//  - in_valid held with in_ready=0: byte stays pending, accepted first cycle in_ready=1.
// CONFIGURATION
//  AUTO_WRAP_EN defined: printable at col==COLS-1 writes the cell, then acts as CR+LF (col=0;
//    row+1 or SCROLL on the bottom line, same timing as LF, write on cycle N+1 precedes clear).
//  AUTO_WRAP_EN undefined: printable at col==COLS-1 writes the cell, cursor stays at COLS-1;
//    further printables overwrite that cell.
// STRUCTURE
//  vt52_pkg: COLS/ROWS localparams, ASCII constants (CR, LF, BS, BLANK, PRINT_LO/HI),
//    state enum {CLEAR_ALL, IDLE, CLEAR_LINE}.
//  Single module; one shared clear counter (10 bit) serves CLEAR_ALL and CLEAR_LINE (low 6 bits).
//  No sub-module: decode, cursor and clear counter are too small to split.
// TESTING
//  1 Release reset -> 1024 wen cycles addr 0..1023 din 8'h20, first_row_wen with 0 on last, then
//    in_ready=1.
//  2 Send 'A','B' -> writes (addr 0,8'h41),(addr 1,8'h42); cursor_col=2; CR -> col 0; BS at col0
//    -> col 0.
//  3 15x LF then 'C' -> addr {4'd15,6'd0}=960 din 8'h43, cursor_row=15.
//  4 At row 15 send LF -> first_row_wen, first_row=1; 64 writes addr 0..63 din 8'h20; in_ready low
//    exactly 64 cycles after accept (N+1..N+64); then 'D' -> addr 0 (phys row 0), cursor_row=15.
//  5 64 printables on one line: AUTO_WRAP_EN -> 65th lands at next row col 0;
//    else 65th overwrites col 63, cursor_col=63.
//  6 Assert clr_n low during CLEAR_LINE cycle 30 -> outputs 0 immediately; after release,
//    full CLEAR_ALL from addr 0.

Source files
------------

// File: rtl/vt52_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vt52_pkg
// Purpose  : Shared geometry, ASCII codes and state encoding for the terminal
//            write controller (char_buffer_ctrl) driving the 64x16 char
//            generator's buffer write ports.
// Contents : COLS/ROWS geometry and derived widths, control character codes,
//            controller state constants, printable-range helper.
// Revision : 1.0  initial release
// ============================================================================
package vt52_pkg;

    // Screen geometry (both powers of two so cursor arithmetic wraps freely)
    localparam int unsigned COLS   = 64;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned ADDR_W = ROW_W + COL_W;

    localparam logic [COL_W-1:0]  COL_MAX = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    // ASCII codes
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] BLANK    = 8'h20;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // Controller states
    localparam logic [1:0] ST_CLEAR_ALL  = 2'd0;
    localparam logic [1:0] ST_IDLE       = 2'd1;
    localparam logic [1:0] ST_CLEAR_LINE = 2'd2;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage : vt52_pkg
`default_nettype wire

// File: rtl/char_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : char_buffer_ctrl
// Purpose  : Terminal write controller for the 64x16 char generator. Accepts
//            a byte stream, owns the cursor, writes printable codes into the
//            char buffer, handles CR/LF/BS and scrolls by advancing the
//            generator's first_row and blanking the recycled line.
// Ports    : clk                  - single clock
//            clr_n                - asynchronous active-low reset
//            in_valid/in_data     - byte offered by host
//            in_ready             - byte accepted when in_valid & in_ready
//            buffer_waddr/din/wen - char buffer write port {phys_row, col}
//            buffer_first_row(_wen) - top-of-screen physical row + load strobe
//            cursor_row/col       - logical cursor position
// Config   : AUTO_WRAP_EN - when defined, a printable written in the last
//            column wraps the cursor like CR+LF (scrolling on the bottom line).
// Revision : 1.0  initial release
// ============================================================================
module char_buffer_ctrl
    import vt52_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] buffer_waddr,
    output logic [7:0]        buffer_din,
    output logic              buffer_wen,
    output logic [ROW_W-1:0]  buffer_first_row,
    output logic              buffer_first_row_wen,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col
);

    logic [1:0]        state_q,     state_d;
    logic [ADDR_W-1:0] cnt_q,       cnt_d;
    logic              in_ready_q,  in_ready_d;
    logic [ADDR_W-1:0] waddr_q,     waddr_d;
    logic [7:0]        din_q,       din_d;
    logic              wen_q,       wen_d;
    logic [ROW_W-1:0]  first_row_q, first_row_d;
    logic              frw_q,       frw_d;
    logic [ROW_W-1:0]  cur_row_q,   cur_row_d;
    logic [COL_W-1:0]  cur_col_q,   cur_col_d;

    logic              accept;
    logic [ROW_W-1:0]  phys_row;

    assign accept   = in_valid && in_ready_q;
    assign phys_row = first_row_q + cur_row_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        waddr_d     = waddr_q;
        din_d       = din_q;
        wen_d       = 1'b0;
        first_row_d = first_row_q;
        frw_d       = 1'b0;
        cur_row_d   = cur_row_q;
        cur_col_d   = cur_col_q;

        case (state_q)
            ST_CLEAR_ALL: begin
                wen_d   = 1'b1;
                waddr_d = cnt_q;
                din_d   = BLANK;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_MAX) begin
                    frw_d       = 1'b1;
                    first_row_d = '0;
                    state_d     = ST_IDLE;
                    // in_ready rises one cycle after the final write
                end
            end

            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    if (is_printable(in_data)) begin
                        wen_d   = 1'b1;
                        waddr_d = {phys_row, cur_col_q};
                        din_d   = in_data;
                        if (cur_col_q != COL_MAX) begin
                            cur_col_d = cur_col_q + COL_W'(1);
                        end
`ifdef AUTO_WRAP_EN
                        else begin
                            cur_col_d = '0;
                            if (cur_row_q != ROW_MAX) begin
                                cur_row_d = cur_row_q + ROW_W'(1);
                            end else begin
                                // The printable owns this cycle's write port;
                                // line blanking starts next cycle at column 0.
                                frw_d       = 1'b1;
                                first_row_d = first_row_q + ROW_W'(1);
                                cnt_d       = '0;
                                in_ready_d  = 1'b0;
                                state_d     = ST_CLEAR_LINE;
                            end
                        end
`endif
                    end else if (in_data == CH_CR) begin
                        cur_col_d = '0;
                    end else if (in_data == CH_BS) begin
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - COL_W'(1);
                        end
                    end else if (in_data == CH_LF) begin
                        if (cur_row_q != ROW_MAX) begin
                            cur_row_d = cur_row_q + ROW_W'(1);
                        end else begin
                            // Scroll: old top line becomes the new bottom.
                            // Column 0 of it is blanked in the same cycle.
                            frw_d       = 1'b1;
                            first_row_d = first_row_q + ROW_W'(1);
                            wen_d       = 1'b1;
                            waddr_d     = {first_row_q, COL_W'(0)};
                            din_d       = BLANK;
                            cnt_d       = ADDR_W'(1);
                            in_ready_d  = 1'b0;
                            state_d     = ST_CLEAR_LINE;
                        end
                    end
                end
            end

            ST_CLEAR_LINE: begin
                // Bit COL_W set means all COLS cells of the line are written.
                if (cnt_q[COL_W]) begin
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    wen_d   = 1'b1;
                    // first_row has already advanced; the recycled line is
                    // the one just above the new top.
                    waddr_d = {first_row_q - ROW_W'(1), cnt_q[COL_W-1:0]};
                    din_d   = BLANK;
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end

            default: begin
                state_d = ST_CLEAR_ALL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_CLEAR_ALL;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            waddr_q     <= '0;
            din_q       <= '0;
            wen_q       <= 1'b0;
            first_row_q <= '0;
            frw_q       <= 1'b0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            waddr_q     <= waddr_d;
            din_q       <= din_d;
            wen_q       <= wen_d;
            first_row_q <= first_row_d;
            frw_q       <= frw_d;
            cur_row_q   <= cur_row_d;
            cur_col_q   <= cur_col_d;
        end
    end

    assign in_ready             = in_ready_q;
    assign buffer_waddr         = waddr_q;
    assign buffer_din           = din_q;
    assign buffer_wen           = wen_q;
    assign buffer_first_row     = first_row_q;
    assign buffer_first_row_wen = frw_q;
    assign cursor_row           = cur_row_q;
    assign cursor_col           = cur_col_q;

endmodule : char_buffer_ctrl
`default_nettype wire

// File: tb/tb_char_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_buffer_ctrl
// Purpose  : Self-checking bench for char_buffer_ctrl. A queue-based model of
//            the terminal (cursor, first_row, list of upcoming per-cycle write
//            activity) predicts the outputs every cycle; directed scenarios
//            add literal expectations; a random byte stream finishes the run.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_char_buffer_ctrl;

    localparam logic [7:0] T_CR = 8'h0D;
    localparam logic [7:0] T_LF = 8'h0A;
    localparam logic [7:0] T_BS = 8'h08;
    localparam logic [7:0] T_SP = 8'h20;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [9:0] buffer_waddr;
    logic [7:0] buffer_din;
    logic       buffer_wen;
    logic [3:0] buffer_first_row;
    logic       buffer_first_row_wen;
    logic [3:0] cursor_row;
    logic [5:0] cursor_col;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    char_buffer_ctrl dut (
        .clk                  (clk),
        .clr_n                (clr_n),
        .in_valid             (in_valid),
        .in_data              (in_data),
        .in_ready             (in_ready),
        .buffer_waddr         (buffer_waddr),
        .buffer_din           (buffer_din),
        .buffer_wen           (buffer_wen),
        .buffer_first_row     (buffer_first_row),
        .buffer_first_row_wen (buffer_first_row_wen),
        .cursor_row           (cursor_row),
        .cursor_col           (cursor_col)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic       busy;   // controller not accepting this cycle
        logic       wen;
        logic [9:0] addr;
        logic [7:0] din;
        logic       frw;
    } item_t;

    item_t      mq[$];
    item_t      cur;
    logic [3:0] m_fr;
    logic [3:0] m_row;
    logic [5:0] m_col;

    function automatic item_t mk(input logic busy, input logic wen, input logic [9:0] a,
                                 input logic [7:0] d, input logic frw);
        item_t it;
        it.busy = busy; it.wen = wen; it.addr = a; it.din = d; it.frw = frw;
        return it;
    endfunction

    // Old top line becomes bottom: 64 blank writes to it, busy throughout.
    task automatic m_scroll(input bit after_print);
        logic [3:0] old;
        old  = m_fr;
        m_fr = m_fr + 4'd1;
        for (int i = 0; i < 64; i++) begin
            logic [9:0] a;
            a = {old, 6'(i)};
            mq.push_back(mk(1'b1, 1'b1, a, T_SP, (i == 0) && !after_print));
        end
    endtask

    task automatic m_accept(input logic [7:0] b);
        logic [3:0] pr;
        pr = m_fr + m_row;
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (m_col != 6'd63) begin
                mq.push_back(mk(1'b0, 1'b1, {pr, m_col}, b, 1'b0));
                m_col = m_col + 6'd1;
            end else begin
`ifdef AUTO_WRAP_EN
                m_col = 6'd0;
                if (m_row != 4'd15) begin
                    mq.push_back(mk(1'b0, 1'b1, {pr, 6'd63}, b, 1'b0));
                    m_row = m_row + 4'd1;
                end else begin
                    mq.push_back(mk(1'b1, 1'b1, {pr, 6'd63}, b, 1'b1));
                    m_scroll(1'b1);
                end
`else
                mq.push_back(mk(1'b0, 1'b1, {pr, 6'd63}, b, 1'b0));
`endif
            end
        end else if (b == T_CR) begin
            m_col = 6'd0;
        end else if (b == T_BS) begin
            if (m_col != 6'd0) m_col = m_col - 6'd1;
        end else if (b == T_LF) begin
            if (m_row != 4'd15) m_row = m_row + 4'd1;
            else m_scroll(1'b0);
        end
    endtask

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            mq.delete();
            for (int i = 0; i < 1024; i++) begin
                logic [9:0] a;
                a = 10'(i);
                mq.push_back(mk(1'b1, 1'b1, a, T_SP, i == 1023));
            end
            cur   = mk(1'b1, 1'b0, 10'd0, 8'd0, 1'b0);
            m_fr  = 4'd0;
            m_row = 4'd0;
            m_col = 6'd0;
        end else begin
            if (in_valid && !cur.busy) m_accept(in_data);
            if (mq.size() > 0) cur = mq.pop_front();
            else cur = mk(1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [34:0] act;
        logic [34:0] exp;
        logic [34:0] mask;
        act = {in_ready, buffer_wen, buffer_waddr, buffer_din, buffer_first_row_wen,
               buffer_first_row, cursor_row, cursor_col};
        if (!clr_n) begin
            exp  = '0;
            mask = '1;
        end else begin
            exp  = {!cur.busy, cur.wen, cur.addr, cur.din, cur.frw, m_fr, m_row, m_col};
            mask = cur.wen ? '1 : {2'b11, 18'b0, 15'h7FFF};
        end
        chk("cycle_outputs", act & mask, exp & mask);
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 2000; k++) begin
            if (in_ready) break;
            @(negedge clk);
        end
        if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic clear_all_check();
        int nw, bad, frw_at;
        nw = 0; bad = 0; frw_at = -1;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            #1;
            if (in_ready) break;
            if (buffer_wen) begin
                if (buffer_waddr != nw[9:0] || buffer_din != T_SP) bad++;
                if (buffer_first_row_wen) frw_at = nw;
                nw++;
            end
        end
        chk("clear_all_write_count", 64'(nw), 64'd1024);
        chk("clear_all_addr_order", 64'(bad), 64'd0);
        chk("clear_all_frw_on_last", 64'(frw_at), 64'd1023);
        chk("ready_after_clear_all", {63'd0, in_ready}, 64'd1);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_state", {in_ready, buffer_wen, buffer_waddr, buffer_din, buffer_first_row_wen,
                            buffer_first_row, cursor_row, cursor_col}, 64'd0);
        #1 clr_n = 1'b1;

        // power-up clear
        clear_all_check();

        // printables, CR, BS at column 0
        send(8'h41);
        chk("A_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'd0, 8'h41});
        send(8'h42);
        chk("B_write", {buffer_wen, buffer_waddr, buffer_din}, {1'b1, 10'd1, 8'h42});
        chk("col_after_AB", 64'(cursor_col), 64'd2);
        send(T_CR);
        chk("CR_col", {buffer_wen, cursor_col}, {1'b0, 6'd0});
        send(T_BS);
        chk("BS_sat_col", {buffer_wen, cursor_col}, {1'b0, 6'd0});

        // move to bottom line
        for (int i = 0; i < 15; i++) send(T_LF);
        send(8'h43);
        chk("C_bottom_write", {buffer_waddr, buffer_din}, {10'd960, 8'h43});
        chk("row_bottom", 64'(cursor_row), 64'd15);

        // scroll
        send(T_LF);
        chk("scroll_first", {buffer_first_row_wen, buffer_first_row, buffer_wen, buffer_waddr, buffer_din},
            {1'b1, 4'd1, 1'b1, 10'd0, T_SP});
        n = 0;
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        chk("scroll_busy_cycles", 64'(n), 64'd64);
        send(T_CR);
        send(8'h44);
        chk("D_after_scroll", {buffer_waddr, buffer_din, cursor_row}, {10'd0, 8'h44, 4'd15});

        // a full line of printables, then one more
        send(T_CR);
        for (int i = 0; i < 64; i++) send(8'(8'h61 + (i % 26)));
        repeat (70) @(negedge clk);
        send(8'h5A);
`ifdef AUTO_WRAP_EN
        chk("wrap_65th", {buffer_waddr[5:0], buffer_din, cursor_col}, {6'd0, 8'h5A, 6'd1});
`else
        chk("nowrap_65th", {buffer_waddr, buffer_din, cursor_col}, {10'd63, 8'h5A, 6'd63});
`endif
        repeat (70) @(negedge clk);

        // reset in the middle of a line clear
        send(T_CR);
        if (cursor_row != 4'd15) for (int i = 0; i < 15; i++) send(T_LF);
        send(T_LF);
        repeat (29) @(negedge clk);
        #2 clr_n = 1'b0;
        #1;
        chk("async_reset_outputs", {in_ready, buffer_wen, buffer_waddr, buffer_din, buffer_first_row_wen,
                                    buffer_first_row, cursor_row, cursor_col}, 64'd0);
        repeat (3) @(negedge clk);
        #2 clr_n = 1'b1;
        clear_all_check();

        // random byte stream
        for (int c = 0; c < 4000; c++) begin
            int r;
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 5)       in_data = 8'($urandom_range(32, 126));
            else if (r == 5) in_data = T_CR;
            else if (r == 6) in_data = T_LF;
            else if (r == 7) in_data = T_BS;
            else             in_data = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (100) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_char_buffer_ctrl
`default_nettype wire
